// File: rtl/ac_cmd_sequencer.sv
// Command sequencer for the ac flop stage: queues SET/CLR/TOG/HOLD commands with
// repeat counts, drives a/c one command-cycle per clock and tracks the flop's q.
module ac_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [CNT_W-1:0]       cmd_cnt,
    input  logic                   q_fb,
    output logic                   a,
    output logic                   c,
    output logic                   busy,
    output logic                   done,
    output logic                   q_model,
    output logic                   model_valid,
    output logic                   mismatch,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CNT_W + 2;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] AC_SET  = 2'b00;
    localparam logic [1:0] AC_CLR  = 2'b01;
    localparam logic [1:0] AC_TOG  = 2'b10;
    localparam logic [1:0] AC_HOLD = 2'b11;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [0:0]       state_q, state_d;
    logic [1:0]       ac_q, ac_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             qModel_q, qModel_d;
    logic             modelValid_q, modelValid_d;
    logic             mismatch_q, mismatch_d;

    logic             push;
    logic             pop;
    logic             fifoEmpty;
    logic [1:0]       headOp;
    logic [CNT_W-1:0] headCnt;

    assign fifoEmpty          = (level_q == '0);
    assign cmd_ready          = (level_q != FULL_LEVEL);
    assign push               = cmd_valid & cmd_ready;
    assign {headOp, headCnt}  = mem_q[rdPtr_q];

    // A command holds a/c while cycles remain; on its last cycle the next one is
    // popped straight away so back-to-back commands run without a bubble.
    always_comb begin
        state_d  = state_q;
        ac_d     = ac_q;
        remain_d = remain_q;
        pop      = 1'b0;
        if ((state_q == RUN) && (remain_q != '0)) begin
            remain_d = remain_q - CNT_W'(1);
        end else if (!fifoEmpty) begin
            pop      = 1'b1;
            ac_d     = headOp;
            remain_d = (headCnt == '0) ? '0 : headCnt - CNT_W'(1);
            state_d  = RUN;
        end else begin
            ac_d    = AC_HOLD;
            state_d = IDLE;
        end
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + AW'(1) : rdPtr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // The ac stage samples ac_q on every edge; q_fb seen now is the result of the
    // previous edge, which is exactly what qModel_q currently holds.
    always_comb begin
        qModel_d     = qModel_q;
        modelValid_d = modelValid_q;
        mismatch_d   = mismatch_q | (modelValid_q & (q_fb ^ qModel_q));
        case (ac_q)
            AC_SET: begin
                qModel_d     = 1'b1;
                modelValid_d = 1'b1;
            end
            AC_CLR: begin
                qModel_d     = 1'b0;
                modelValid_d = 1'b1;
            end
            AC_TOG:  qModel_d = ~qModel_q;
            default: qModel_d = qModel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            state_q      <= IDLE;
            ac_q         <= AC_HOLD;
            remain_q     <= '0;
            qModel_q     <= 1'b0;
            modelValid_q <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            level_q      <= level_d;
            state_q      <= state_d;
            ac_q         <= ac_d;
            remain_q     <= remain_d;
            qModel_q     <= qModel_d;
            modelValid_q <= modelValid_d;
            mismatch_q   <= mismatch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {cmd_op, cmd_cnt};
        end
    end

    assign a           = ac_q[1];
    assign c           = ac_q[0];
    assign done        = (state_q == RUN) && (remain_q == '0);
    assign busy        = (state_q == RUN) || !fifoEmpty;
    assign q_model     = qModel_q;
    assign model_valid = modelValid_q;
    assign mismatch    = mismatch_q;
    assign level       = level_q;

endmodule

// File: tb/tb_ac_cmd_sequencer.sv
// Self-checking bench for ac_cmd_sequencer: a queue-based command model predicts
// a/c, done, busy, level and the ac-stage q cycle by cycle.
module tb_ac_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             q_fb;
    logic             a;
    logic             c;
    logic             busy;
    logic             done;
    logic             q_model;
    logic             model_valid;
    logic             mismatch;
    logic [2:0]       level;
    logic [9:0]       obs;

    int passCount = 0;
    int checkCount = 0;

    // Reference model: pending stimulus, FIFO contents, current command and the
    // ac stage's q (the stage itself is never reset).
    logic [5:0] pend[$];
    logic [5:0] mFifo[$];
    logic [1:0] mOp = 2'b11;
    int         mLeft = 0;
    logic       mQ = 1'b0;
    logic       mValid = 1'b0;
    logic       mMismatch = 1'b0;
    logic       flip = 1'b0;

    ac_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .q_fb(q_fb), .a(a), .c(c),
        .busy(busy), .done(done), .q_model(q_model), .model_valid(model_valid),
        .mismatch(mismatch), .level(level)
    );

    assign q_fb = mQ ^ flip;
    assign obs  = {a, c, done, busy, cmd_ready, level, mismatch, model_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] acOf(input logic [1:0] op);
        case (op)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [9:0] expVec();
        logic [1:0] acE;
        logic [2:0] lv;
        acE = (mLeft > 0) ? acOf(mOp) : 2'b11;
        lv  = 3'(mFifo.size());
        return {acE, (mLeft == 1), ((mLeft > 0) || (mFifo.size() != 0)),
                (mFifo.size() < DEPTH), lv, mMismatch, mValid};
    endfunction

    task automatic modelReset();
        mFifo.delete();
        pend.delete();
        mLeft     = 0;
        mValid    = 1'b0;
        mMismatch = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Offers the head of pend (when allowed), advances one edge and updates the model.
    task automatic applyStimulus(input bit offer);
        logic [1:0] acNow;
        logic [5:0] offered;
        logic [5:0] head;
        bit         acc;
        logic       qNow;
        logic       validNow;
        logic       qfbNow;
        cmd_valid = offer && (pend.size() > 0);
        offered   = (pend.size() > 0) ? pend[0] : 6'h3f;
        cmd_op    = offered[5:4];
        cmd_cnt   = offered[3:0];
        acc       = cmd_valid && (mFifo.size() < DEPTH);
        acNow     = (mLeft > 0) ? acOf(mOp) : 2'b11;
        qNow      = mQ;
        validNow  = mValid;
        qfbNow    = mQ ^ flip;
        @(posedge clk);
        #1;
        if (validNow && (qfbNow != qNow)) mMismatch = 1'b1;
        case (acNow)
            2'b00: begin mQ = 1'b1; mValid = 1'b1; end
            2'b01: begin mQ = 1'b0; mValid = 1'b1; end
            2'b10: mQ = ~mQ;
            default: mQ = mQ;
        endcase
        if (mLeft > 1) begin
            mLeft--;
        end else if (mFifo.size() > 0) begin
            head  = mFifo.pop_front();
            mOp   = head[5:4];
            mLeft = (head[3:0] == 4'd0) ? 1 : int'(head[3:0]);
        end else begin
            mLeft = 0;
        end
        if (acc) begin
            mFifo.push_back(offered);
            pend.delete(0);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_cnt   = '0;
        rst_n     = 1'b1;
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if (obs !== expVec()) $display("[TB] FAIL reset_vec: got %h expected %h", obs, expVec());
        else passCount++;
        checkCount++;
        if ({a, c, level, cmd_ready, busy, mismatch} !== {2'b11, 3'd0, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL reset_outs: got a%b c%b lvl%0d rdy%b busy%b mm%b", a, c, level, cmd_ready, busy, mismatch);
        else passCount++;
        checkCount++;
        if (q_model !== 1'b0) $display("[TB] FAIL reset_qmodel: got %b expected 0", q_model);
        else passCount++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_set_clr();
        logic [1:0] acSeq [5];
        acSeq = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b11};
        pend.push_back({2'd0, 4'd1});
        pend.push_back({2'd1, 4'd1});
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL setclr_vec cyc%0d: got %h expected %h", i, obs, expVec());
            else passCount++;
            checkCount++;
            if ({a, c} !== acSeq[i]) $display("[TB] FAIL setclr_ac cyc%0d: got %b expected %b", i, {a, c}, acSeq[i]);
            else passCount++;
            if (mValid) begin
                checkCount++;
                if (q_model !== mQ) $display("[TB] FAIL setclr_q cyc%0d: got %b expected %b", i, q_model, mQ);
                else passCount++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] acSeq [7];
        logic       qSeq [7];
        acSeq = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        qSeq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pend.push_back({2'd0, 4'd1});
        pend.push_back({2'd2, 4'd4});
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL b2b_vec cyc%0d: got %h expected %h", i, obs, expVec());
            else passCount++;
            checkCount++;
            if ({a, c} !== acSeq[i]) $display("[TB] FAIL b2b_ac cyc%0d: got %b expected %b", i, {a, c}, acSeq[i]);
            else passCount++;
            if (i >= 2) begin
                checkCount++;
                if (q_model !== qSeq[i]) $display("[TB] FAIL b2b_q cyc%0d: got %b expected %b", i, q_model, qSeq[i]);
                else passCount++;
            end
        end
    endtask

    task automatic test_stall_full();
        logic [1:0] doneAc[$];
        logic [1:0] expOrder [6];
        bit         sawFull;
        expOrder = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        sawFull  = 1'b0;
        pend.push_back({2'd3, 4'd15});
        pend.push_back({2'd0, 4'd1});
        pend.push_back({2'd1, 4'd2});
        pend.push_back({2'd2, 4'd1});
        pend.push_back({2'd0, 4'd1});
        pend.push_back({2'd1, 4'd0});
        for (int i = 0; i < 28; i++) begin
            applyStimulus(1'b1);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL stall_vec cyc%0d: got %h expected %h", i, obs, expVec());
            else passCount++;
            if (done === 1'b1) doneAc.push_back({a, c});
            if ((cmd_ready === 1'b0) && (level === 3'd4)) sawFull = 1'b1;
        end
        checkCount++;
        if (sawFull !== 1'b1) $display("[TB] FAIL stall_full: got sawFull=%b expected 1", sawFull);
        else passCount++;
        checkCount++;
        if (doneAc.size() != 6) $display("[TB] FAIL stall_count: got %0d done pulses expected 6", doneAc.size());
        else passCount++;
        for (int i = 0; i < 6; i++) begin
            if (i < doneAc.size()) begin
                checkCount++;
                if (doneAc[i] !== expOrder[i]) $display("[TB] FAIL stall_order idx%0d: got %b expected %b", i, doneAc[i], expOrder[i]);
                else passCount++;
            end
        end
    endtask

    task automatic test_cnt_zero();
        logic [1:0] acSeq [4];
        logic       doneSeq [4];
        acSeq   = '{2'b11, 2'b01, 2'b11, 2'b11};
        doneSeq = '{1'b0, 1'b1, 1'b0, 1'b0};
        pend.push_back({2'd1, 4'd0});
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL cnt0_vec cyc%0d: got %h expected %h", i, obs, expVec());
            else passCount++;
            checkCount++;
            if ({a, c, done} !== {acSeq[i], doneSeq[i]})
                $display("[TB] FAIL cnt0_acdone cyc%0d: got %b expected %b", i, {a, c, done}, {acSeq[i], doneSeq[i]});
            else passCount++;
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 24; i++) begin
            pend.push_back({2'($urandom_range(0, 3)), 4'($urandom_range(0, 3))});
        end
        pend.push_back({2'd2, 4'd15});
        cyc = 0;
        while (((pend.size() != 0) || (mLeft != 0) || (mFifo.size() != 0)) && (cyc < 400)) begin
            applyStimulus($urandom_range(0, 3) != 0);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL rand_vec cyc%0d: got %h expected %h", cyc, obs, expVec());
            else passCount++;
            if (mValid) begin
                checkCount++;
                if (q_model !== mQ) $display("[TB] FAIL rand_q cyc%0d: got %b expected %b", cyc, q_model, mQ);
                else passCount++;
            end
            cyc++;
        end
        checkCount++;
        if ((pend.size() != 0) || (busy !== 1'b0))
            $display("[TB] FAIL rand_drain: got pending=%0d busy=%b expected 0/0", pend.size(), busy);
        else passCount++;
    endtask

    task automatic test_mismatch_reset();
        pend.push_back({2'd0, 4'd1});
        pend.push_back({2'd2, 4'd8});
        for (int i = 0; i < 7; i++) begin
            flip = (i == 3);
            applyStimulus(1'b1);
            checkCount++;
            if (obs !== expVec()) $display("[TB] FAIL mm_vec cyc%0d: got %h expected %h", i, obs, expVec());
            else passCount++;
            if (i >= 3) begin
                checkCount++;
                if (mismatch !== 1'b1) $display("[TB] FAIL mm_sticky cyc%0d: got %b expected 1", i, mismatch);
                else passCount++;
            end
        end
        flip = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if ({a, c, level, mismatch} !== {2'b11, 3'd0, 1'b0})
            $display("[TB] FAIL mm_reset: got a%b c%b lvl%0d mm%b expected 1 1 0 0", a, c, level, mismatch);
        else passCount++;
        checkCount++;
        if (obs !== expVec()) $display("[TB] FAIL mm_reset_vec: got %h expected %h", obs, expVec());
        else passCount++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_back_to_back();
        test_stall_full();
        test_cnt_zero();
        test_random();
        test_mismatch_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
